// File: rtl/instruction_buffer_if.sv
// Load and issue signals of the instruction buffer. The master modport is the
// program loader / pipeline controller side and the slave modport is the buffer.
interface instruction_buffer_if #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned IW    = 25
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic          load_valid;
  logic          load_ready;
  logic [IW-1:0] load_instr;
  logic          load_last;
  logic          start;
  logic          stall;
  logic [IW-1:0] instr_out;
  logic          instr_valid;
  logic [AW-1:0] pc;
  logic [AW:0]   count;
  logic          busy;
  logic          done;

  modport master (
    output load_valid, load_instr, load_last, start, stall,
    input  load_ready, instr_out, instr_valid, pc, count, busy, done
  );

  modport slave (
    input  load_valid, load_instr, load_last, start, stall,
    output load_ready, instr_out, instr_valid, pc, count, busy, done
  );
endinterface

// File: rtl/instruction_buffer.sv
// Instruction store and issue stage: loads a program, issues it one word per cycle,
// then issues DRAIN NOPs so EX/WB empty before reporting done.
module instruction_buffer #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned IW    = 25,
  parameter int unsigned DRAIN = 3
) (
  input logic                 clk,
  input logic                 rst,
  instruction_buffer_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned DW = (DRAIN > 1) ? $clog2(DRAIN) : 1;
  localparam logic [CW-1:0] Full      = CW'(DEPTH);
  localparam logic [DW-1:0] DrainLast = DW'((DRAIN > 0) ? DRAIN - 1 : 0);

  typedef enum logic [2:0] {StLoad, StReady, StRun, StDrain, StDone} state_e;

  state_e        state_q;
  logic [CW-1:0] count_q;
  logic [AW-1:0] idx_q;
  logic [AW-1:0] pc_q;
  logic [DW-1:0] drain_q;
  logic [IW-1:0] instr_q;
  logic          valid_q;
  logic          wr_en;

  logic [IW-1:0] mem [DEPTH];

  assign bus.load_ready  = (state_q == StLoad) && (count_q < Full);
  assign wr_en           = bus.load_valid && bus.load_ready;
  assign bus.count       = count_q;
  assign bus.pc          = pc_q;
  assign bus.instr_out   = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.busy        = (state_q == StRun) || (state_q == StDrain);
  assign bus.done        = (state_q == StDone);

  // Storage is deliberately left out of reset so a reset does not cost a clear sweep.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[count_q[AW-1:0]] <= bus.load_instr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StLoad;
      count_q <= '0;
      idx_q   <= '0;
      pc_q    <= '0;
      drain_q <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        StLoad: begin
          if (wr_en) begin
            count_q <= count_q + 1'b1;
            if (bus.load_last || (count_q == Full - 1'b1)) begin
              state_q <= StReady;
            end
          end
        end
        StReady: begin
          if (bus.start) begin
            idx_q   <= '0;
            drain_q <= '0;
            state_q <= (count_q == '0) ? StDrain : StRun;
          end
        end
        StRun: begin
          if (!bus.stall) begin
            instr_q <= mem[idx_q];
            pc_q    <= idx_q;
            valid_q <= 1'b1;
            idx_q   <= idx_q + 1'b1;
            // Last word leaves this edge; the next free cycle already issues a NOP.
            if ({1'b0, idx_q} == count_q - 1'b1) begin
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          if (!bus.stall) begin
            instr_q <= '0;
            valid_q <= 1'b0;
            drain_q <= drain_q + 1'b1;
            if (drain_q == DrainLast) begin
              state_q <= StDone;
            end
          end
        end
        StDone: begin
          instr_q <= '0;
          valid_q <= 1'b0;
        end
        default: state_q <= StLoad;
      endcase
    end
  end
endmodule

// File: tb/tb_instruction_buffer.sv
// Scoreboard bench for instruction_buffer: the driver queues expected issue words,
// a negedge monitor pops one per issue cycle (busy and not stalled) and compares.
module tb_instruction_buffer;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned IW    = 25;
  localparam int unsigned DRAIN = 3;
  localparam int unsigned AW    = 6;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  instruction_buffer_if #(.DEPTH(DEPTH), .IW(IW)) bus ();

  instruction_buffer #(
    .DEPTH(DEPTH),
    .IW   (IW),
    .DRAIN(DRAIN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [IW-1:0] instr;
    logic [AW-1:0] pc;
    logic          valid;
  } exp_t;

  exp_t          sb[$];
  logic [IW-1:0] model[$];
  int            checks   = 0;
  int            failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string msg);
    checks++;
    failures++;
    $display("FAIL %s: %s", name, msg);
  endtask

  // Monitor: an issue happens on each edge where busy was high and stall low.
  initial begin : monitor
    bit pend;
    exp_t e;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          if (sb.size() == 0) begin
            fail_now("unexpected_issue", $sformatf("got instr 0x%0h pc %0d, required none",
                                                   bus.instr_out, bus.pc));
          end else begin
            e = sb.pop_front();
            check("issue_instr", bus.instr_out, e.instr);
            check("issue_pc", bus.pc, e.pc);
            check("issue_valid", bus.instr_valid, e.valid);
          end
        end
        pend = bus.busy && !bus.stall;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_instr_out"}, bus.instr_out, 0);
    check({tag, "_instr_valid"}, bus.instr_valid, 0);
    check({tag, "_pc"}, bus.pc, 0);
    check({tag, "_count"}, bus.count, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_load_ready"}, bus.load_ready, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.load_valid = 1'b0;
    bus.load_instr = '0;
    bus.load_last  = 1'b0;
    bus.start      = 1'b0;
    bus.stall      = 1'b0;
    sb.delete();
    model.delete();
    #1;
    check_reset_outputs("rst");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load_word(input logic [IW-1:0] w, input bit last);
    bit hs;
    int n;
    hs = 1'b0;
    n  = 0;
    bus.load_valid = 1'b1;
    bus.load_instr = w;
    bus.load_last  = last;
    while (!hs && n < 20) begin
      @(negedge clk);
      hs = bus.load_ready;
      @(posedge clk);
      #1;
      n++;
    end
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    if (hs) model.push_back(w);
    else fail_now("load_handshake", "no load_ready within 20 cycles");
  endtask

  task automatic push_expect();
    logic [AW-1:0] lpc;
    lpc = (model.size() == 0) ? '0 : AW'(model.size() - 1);
    foreach (model[i]) sb.push_back('{instr: model[i], pc: AW'(i), valid: 1'b1});
    for (int i = 0; i < DRAIN; i++) sb.push_back('{instr: '0, pc: lpc, valid: 1'b0});
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic run_program(input int stall_at, input int stall_len, input int exp_busy,
                             input string tag);
    int  busy_n;
    int  n;
    bit  stalled;
    busy_n  = 0;
    n       = 0;
    stalled = 1'b0;
    push_expect();
    pulse_start();
    while (!bus.done && n < 400) begin
      if (bus.busy) busy_n++;
      if (!stalled && stall_len > 0 && bus.instr_valid && bus.pc == AW'(stall_at)) begin
        stalled   = 1'b1;
        bus.stall = 1'b1;
        for (int k = 0; k < stall_len; k++) begin
          @(posedge clk);
          #1;
          n++;
          if (bus.busy) busy_n++;
          check({tag, "_stall_pc"}, bus.pc, stall_at);
          check({tag, "_stall_instr"}, bus.instr_out, model[stall_at]);
        end
        bus.stall = 1'b0;
      end
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.done) fail_now({tag, "_done_timeout"}, "done not seen within 400 cycles");
    check({tag, "_busy_cycles"}, busy_n, exp_busy);
    @(posedge clk);
    #1;
    check({tag, "_sb_left"}, sb.size(), 0);
    check({tag, "_done"}, bus.done, 1);
    check({tag, "_busy_end"}, bus.busy, 0);
    check({tag, "_instr_end"}, bus.instr_out, 0);
    check({tag, "_valid_end"}, bus.instr_valid, 0);
  endtask

  initial begin : driver
    int n;

    // Basic 4-word run.
    do_reset();
    load_word(25'h0000021, 1'b0);
    load_word(25'h0000442, 1'b0);
    load_word(25'h0000863, 1'b0);
    load_word(25'h1000084, 1'b1);
    check("t1_count", bus.count, 4);
    check("t1_ready_state", bus.load_ready, 0);
    run_program(0, 0, 4 + DRAIN, "t1");
    pulse_start();
    idle(3);
    check("t1_done_hold", bus.done, 1);
    check("t1_done_busy", bus.busy, 0);

    // Full buffer, then a rejected 65th word.
    do_reset();
    for (int i = 0; i < DEPTH; i++) load_word(IW'(32'h0013579 * (i + 1) + i), 1'b0);
    check("t2_load_ready", bus.load_ready, 0);
    check("t2_count", bus.count, 64);
    bus.load_valid = 1'b1;
    bus.load_instr = 25'h1BADBAD;
    idle(2);
    bus.load_valid = 1'b0;
    check("t2_count_after_extra", bus.count, 64);
    run_program(0, 0, DEPTH + DRAIN, "t2");

    // Stall at pc=1 for 3 cycles.
    do_reset();
    load_word(25'h0000021, 1'b0);
    load_word(25'h0000442, 1'b0);
    load_word(25'h0000863, 1'b0);
    load_word(25'h1000084, 1'b1);
    run_program(1, 3, 4 + DRAIN + 3, "t3");

    // Start ignored in LOAD, then a single-word program.
    do_reset();
    pulse_start();
    idle(3);
    check("t4_busy_in_load", bus.busy, 0);
    check("t4_ready_in_load", bus.load_ready, 1);
    check("t4_count_in_load", bus.count, 0);
    load_word(25'h0ABCDEF, 1'b1);
    check("t4_count", bus.count, 1);
    run_program(0, 0, 1 + DRAIN, "t4");

    // Asynchronous reset while pc=2 is on the output.
    do_reset();
    for (int i = 0; i < 6; i++) load_word(IW'(32'h00100 + i), i == 5);
    push_expect();
    pulse_start();
    n = 0;
    while (!(bus.instr_valid && bus.pc == 2) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50) fail_now("t5_reach_pc2", "pc=2 not seen within 50 cycles");
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("t5_async");
    do_reset();
    check("t5_load_ready", bus.load_ready, 1);

    // Fresh program loaded with idle gaps between words.
    load_word(25'h00ABCDE, 1'b0);
    check("t6_count1", bus.count, 1);
    idle(1);
    check("t6_gap1", bus.count, 1);
    load_word(25'h1FFFFFF, 1'b0);
    idle(3);
    check("t6_gap2", bus.count, 2);
    load_word(25'h0000001, 1'b0);
    idle(2);
    check("t6_gap3", bus.count, 3);
    load_word(25'h1555555, 1'b1);
    check("t6_count4", bus.count, 4);
    run_program(0, 0, 4 + DRAIN, "t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instruction_buffer.md
Name: instruction_buffer

Overview:
- Instruction store and issue stage at the front of the pipelined SIMD unit.
- Accepts a program of 25-bit instructions over a valid/ready load interface into an internal memory.
- On start, issues one instruction per cycle to the decode/register-read stage that feeds EX and the forwarding logic.
- After the last instruction, issues a fixed number of NOPs (all-zero words) so the EX and WB stages drain, then reports done.

Parameters:
- DEPTH, 64, number of instruction slots (power of two).
- IW, 25, instruction width in bits.
- DRAIN, 3, number of NOP cycles issued after the last program instruction.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- load_valid  input  1  load_instr is valid this cycle.
- load_ready  output  1  buffer can accept a load word.
- load_instr  input  IW  instruction word to store.
- load_last  input  1  qualifies the final word of the program (sampled with load_valid).
- start  input  1  begin issue (one-cycle pulse or level).
- stall  input  1  hold issue; outputs frozen.
- instr_out  output  IW  issued instruction to the decode stage; 0 = NOP.
- instr_valid  output  1  instr_out holds a program instruction (not a drain NOP).
- pc  output  log2(DEPTH)  index of the instruction in instr_out.
- count  output  log2(DEPTH)+1  number of words loaded.
- busy  output  1  high in RUN and DRAIN.
- done  output  1  high in DONE.

Behaviour:
- Reset:
  - Reset is asynchronous and active-high, named rst; single clock clk.
  - Reset enters state LOAD.
  - All outputs reset to 0, except load_ready, which is 1 once in LOAD.
  - Write pointer, count, pc and drain counter reset to 0.
  - Memory contents are not cleared.
  - Reset mid-RUN or mid-DRAIN aborts immediately; the next cycle behaves as after power-up reset.
- States: LOAD, READY, RUN, DRAIN, DONE.
- LOAD:
  - load_ready = (count < DEPTH).
  - A handshake occurs when load_valid && load_ready: mem[count] <= load_instr; count++.
  - Transition to READY on a handshake with load_last=1, or on the handshake that makes count == DEPTH.
  - start is ignored in LOAD.
  - load_valid while load_ready=0 is not accepted and has no effect.
- READY:
  - load_ready=0.
  - On start=1: if count==0, go to DRAIN; otherwise go to RUN with an internal read index of 0.
- RUN:
  - Outputs are registered: instr_out/pc/instr_valid update on the clock edge after the read index is presented.
  - The first program instruction appears exactly 1 cycle after start is sampled in READY.
  - Each cycle with stall=0: instr_out <= mem[idx], pc <= idx, instr_valid <= 1, idx++.
  - With stall=1: instr_out, pc, instr_valid and idx all hold.
  - After mem[count-1] is issued (and not stalled), the next non-stalled cycle enters DRAIN.
- DRAIN:
  - Each non-stalled cycle issues instr_out=0, instr_valid=0; pc holds its last value.
  - Exactly DRAIN non-stalled NOP cycles are issued, then the block moves to DONE.
  - stall freezes the drain counter.
- DONE:
  - done=1, busy=0, instr_out=0, instr_valid=0.
  - The block stays in DONE until rst. start is ignored.
- busy is 1 exactly in RUN and DRAIN. It asserts the cycle after start is accepted and falls the cycle done rises.
- Simultaneous start and stall in READY: the RUN transition is taken, and the first instruction is held until stall deasserts.
- Simultaneous load_last and count reaching DEPTH: a single transition to READY occurs.
- Widths:
  - count is one bit wider than pc so that DEPTH is representable.
  - pc never wraps during RUN, because issue stops at count-1.

Test Plan:
1. Basic run, DRAIN=3:
   - Stimulus: reset; load 4 words 0x0000021, 0x0000442, 0x0000863, 0x1000084 with load_last on the 4th; start pulse.
   - Required: count=4; READY 1 cycle after the 4th handshake; instr_out shows the 4 words on consecutive cycles with pc 0..3, instr_valid=1; then 3 cycles of instr_out=0, instr_valid=0; then done=1; busy high for exactly 7 cycles.
2. Full buffer, DEPTH=64:
   - Stimulus: load 64 words with load_last=0; drive load_valid on a 65th cycle.
   - Required: load_ready drops after the 64th handshake; state is READY; count=64; the 65th word is not stored; on run, pc reaches 63 then DRAIN.
3. Stall handling:
   - Stimulus: in RUN at pc=1, assert stall for 3 cycles.
   - Required: instr_out and pc hold at word 1 for the 3 cycles; word 2 appears the cycle after stall falls; total busy length increases by exactly 3.
4. Empty program:
   - Stimulus: assert load_valid with load_last on the first word, then issue start. Separately, force count=0 via reset then start is ignored in LOAD.
   - Required:
     - First case: count=1, one instruction issued.
     - Second case: start in LOAD has no effect and busy stays 0.
5. Reset mid-operation:
   - Stimulus: assert rst asynchronously (between clock edges) while in RUN at pc=2.
   - Required: instr_out=0, instr_valid=0, pc=0, busy=0, count=0 immediately (no clock needed); load_ready=1 afterwards; a fresh program loads and runs correctly.
6. Load backpressure and gaps:
   - Stimulus: toggle load_valid with idle gaps between words.
   - Required: only handshake cycles increment count; words are stored in order and are issued in the same order.
